// File: rtl/sflag_pkg.sv
// Shared definitions for the session-flag write sequencer: target/saddr codes,
// Select action enum, FSM encoding and the action-table evaluation function.
package sflag_pkg;

  localparam logic [2:0] TGT_S0 = 3'b000;
  localparam logic [2:0] TGT_S1 = 3'b001;
  localparam logic [2:0] TGT_S2 = 3'b010;
  localparam logic [2:0] TGT_S3 = 3'b011;
  localparam logic [2:0] TGT_SL = 3'b100;

  localparam logic [1:0] SADDR_S1 = 2'b00;
  localparam logic [1:0] SADDR_S2 = 2'b01;
  localparam logic [1:0] SADDR_S3 = 2'b10;
  localparam logic [1:0] SADDR_SL = 2'b11;

  // Named as <matching half>_<non-matching half>
  typedef enum logic [2:0] {
    ACT_ASRT_DSRT = 3'd0,
    ACT_ASRT_NOP  = 3'd1,
    ACT_NOP_DSRT  = 3'd2,
    ACT_NEG_NOP   = 3'd3,
    ACT_DSRT_ASRT = 3'd4,
    ACT_DSRT_NOP  = 3'd5,
    ACT_NOP_ASRT  = 3'd6,
    ACT_NOP_NEG   = 3'd7
  } act_e;

  typedef enum logic [1:0] {OP_NOP, OP_ASRT, OP_DSRT, OP_NEG} op_e;

  typedef enum logic [3:0] {
    ST_INIT_HOLD, ST_INIT_RD, ST_INIT_WAIT, ST_IDLE,
    ST_RD, ST_WAIT, ST_CALC, ST_WR, ST_FIN
  } state_e;

  typedef struct packed {
    logic new_val;
    logic wr_en;
  } act_res_t;

  function automatic act_res_t act_eval(act_e act, logic match, logic old,
                                        logic is_sl, logic inv);
    op_e      op;
    act_res_t r;
    op = OP_NOP;
    case (act)
      ACT_ASRT_DSRT: op = match ? OP_ASRT : OP_DSRT;
      ACT_ASRT_NOP:  op = match ? OP_ASRT : OP_NOP;
      ACT_NOP_DSRT:  op = match ? OP_NOP  : OP_DSRT;
      ACT_NEG_NOP:   op = match ? OP_NEG  : OP_NOP;
      ACT_DSRT_ASRT: op = match ? OP_DSRT : OP_ASRT;
      ACT_DSRT_NOP:  op = match ? OP_DSRT : OP_NOP;
      ACT_NOP_ASRT:  op = match ? OP_NOP  : OP_ASRT;
      ACT_NOP_NEG:   op = match ? OP_NOP  : OP_NEG;
      default:       op = OP_NOP;
    endcase
    if (inv) op = OP_NEG;
    r.wr_en = 1'b1;
    // SL asserts to 1; inventoried flags assert to A (0)
    case (op)
      OP_ASRT: r.new_val = is_sl;
      OP_DSRT: r.new_val = ~is_sl;
      OP_NEG:  r.new_val = ~old;
      default: begin
        r.new_val = old;
        r.wr_en   = 1'b0;
      end
    endcase
    return r;
  endfunction

  function automatic logic [1:0] map_saddr(logic [2:0] tgt);
    case (tgt)
      TGT_S2:  return SADDR_S2;
      TGT_S3:  return SADDR_S3;
      TGT_SL:  return SADDR_SL;
      default: return SADDR_S1;
    endcase
  endfunction

  function automatic logic is_store(logic [2:0] tgt);
    return (tgt >= TGT_S1) && (tgt <= TGT_SL);
  endfunction

endpackage

// File: rtl/sflag_act_lut.sv
// Combinational Select action-table evaluator; also used by the Query-session
// logic, so it stays free of any sequencing state.
module sflag_act_lut
  import sflag_pkg::*;
(
  input  logic [2:0] act,
  input  logic       match,
  input  logic       old,
  input  logic       is_sl,
  input  logic       inv,
  output logic       new_val,
  output logic       wr_en
);

  act_res_t res;

  assign res     = act_eval(act_e'(act), match, old, is_sl, inv);
  assign new_val = res.new_val;
  assign wr_en   = res.wr_en;

endmodule

// File: rtl/sflag_wr_seq.sv
// Session-flag read-modify-write sequencer. Optional ERR output under
// `SFLAG_ILLEGAL_ERR_EN (illegal target or out-of-range RD_LAT).
//
// state        | meaning
// INIT_HOLD    | post-reset idle, counts INIT_HOLD cycles
// INIT_RD      | initial storage read strobe
// INIT_WAIT    | waits RD_LAT cycles for the initial read
// IDLE         | RDY=1, accepts sel_req / inv_req
// RD           | per-command read strobe, saddr driven
// WAIT         | RD_LAT cycles, srdata captured in the last one
// CALC         | evaluates the action table, updates S0 locally
// WR           | write strobe with saddr/swdata
// FIN          | DONE pulse
module sflag_wr_seq
  import sflag_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter int INIT_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_req,
  input  logic [2:0] sel_target,
  input  logic [2:0] sel_action,
  input  logic       sel_match,
  input  logic       inv_req,
  input  logic [1:0] inv_sess,
  input  logic       srdata,
  output logic       init_srd_pulse,
  output logic       par_srd_pulse,
  output logic       swr_pulse,
  output logic [1:0] saddr,
  output logic       swdata,
  output logic       S0,
  output logic       RDY,
  output logic       DONE
`ifdef SFLAG_ILLEGAL_ERR_EN
  ,output logic      ERR
`endif
);

  localparam int CNT_W = 4;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       tgt_q;
  logic [2:0]       act_q;
  logic             match_q;
  logic             inv_q;
  logic             rd_val;
  logic             old_val;
  logic             lut_new;
  logic             lut_we;
  logic             fin_now;

  assign old_val = (tgt_q == TGT_S0) ? S0 : rd_val;

  sflag_act_lut u_lut (
    .act    (act_q),
    .match  (match_q),
    .old    (old_val),
    .is_sl  (tgt_q == TGT_SL),
    .inv    (inv_q),
    .new_val(lut_new),
    .wr_en  (lut_we)
  );

  // Everything except a storage write leaves CALC straight for FIN
  always_comb begin
    fin_now = 1'b0;
    if (state == ST_WR) fin_now = 1'b1;
    else if (state == ST_CALC) fin_now = !(is_store(tgt_q) && lut_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT_HOLD;
      cnt            <= '0;
      tgt_q          <= TGT_S0;
      act_q          <= '0;
      match_q        <= 1'b0;
      inv_q          <= 1'b0;
      rd_val         <= 1'b0;
      init_srd_pulse <= 1'b0;
      par_srd_pulse  <= 1'b0;
      swr_pulse      <= 1'b0;
      saddr          <= SADDR_S1;
      swdata         <= 1'b0;
      S0             <= 1'b0;
      RDY            <= 1'b0;
      DONE           <= 1'b0;
    end else begin
      init_srd_pulse <= 1'b0;
      par_srd_pulse  <= 1'b0;
      swr_pulse      <= 1'b0;
      DONE           <= 1'b0;
      case (state)
        ST_INIT_HOLD: begin
          if (cnt == CNT_W'(INIT_HOLD)) begin
            state          <= ST_INIT_RD;
            init_srd_pulse <= 1'b1;
            saddr          <= SADDR_S1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_INIT_RD: begin
          state <= ST_INIT_WAIT;
          cnt   <= CNT_W'(RD_LAT - 1);
        end
        ST_INIT_WAIT: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            RDY   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (sel_req) begin
            tgt_q   <= sel_target;
            act_q   <= sel_action;
            match_q <= sel_match;
            inv_q   <= 1'b0;
            RDY     <= 1'b0;
            if (is_store(sel_target)) begin
              state         <= ST_RD;
              par_srd_pulse <= 1'b1;
              saddr         <= map_saddr(sel_target);
            end else begin
              state <= ST_CALC;
            end
          end else if (inv_req) begin
            tgt_q   <= {1'b0, inv_sess};
            act_q   <= '0;
            match_q <= 1'b0;
            inv_q   <= 1'b1;
            RDY     <= 1'b0;
            if (inv_sess == 2'd0) begin
              state <= ST_CALC;
            end else begin
              state         <= ST_RD;
              par_srd_pulse <= 1'b1;
              saddr         <= map_saddr({1'b0, inv_sess});
            end
          end
        end
        ST_RD: begin
          state <= ST_WAIT;
          cnt   <= CNT_W'(RD_LAT - 1);
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rd_val <= srdata;
            state  <= ST_CALC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CALC: begin
          if (tgt_q == TGT_S0 && lut_we) S0 <= lut_new;
          if (!fin_now) begin
            state     <= ST_WR;
            swr_pulse <= 1'b1;
            swdata    <= lut_new;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          RDY   <= 1'b1;
        end
        default: ;
      endcase
      if (fin_now) begin
        state <= ST_FIN;
        DONE  <= 1'b1;
      end
    end
  end

`ifdef SFLAG_ILLEGAL_ERR_EN
  localparam logic RD_LAT_BAD = (RD_LAT < 1) || (RD_LAT > 7);
  logic err_pend;

  // A bad RD_LAT is reported once, on the first DONE after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ERR      <= 1'b0;
      err_pend <= RD_LAT_BAD;
    end else begin
      ERR <= 1'b0;
      if (fin_now) begin
        ERR      <= (tgt_q > TGT_SL) || err_pend;
        err_pend <= 1'b0;
      end
    end
  end
`endif

endmodule
